// File: rtl/div_pkg.sv
// Shared types and constants for the SDiv request dispatcher.
package div_pkg;

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Divide-by-zero saturation values for the default operand width.
    localparam logic [W-1:0] DZ_POS = 16'h7FFF;
    localparam logic [W-1:0] DZ_NEG = 16'h8000;

    typedef struct packed {
        logic [W-1:0] dividend;
        logic [W-1:0] divisor;
    } req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO: power-of-two depth, head entry visible combinationally.
module div_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] head_c,
    output logic          full_c,
    output logic          empty_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign full_c    = (count_q == CW'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign push_ok_c = push_i && !full_c;
    assign pop_ok_c  = pop_i && !empty_c;
    assign head_c    = mem_q[rd_ptr_q];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/div_dispatch.sv
// Buffers divide requests, issues them to SDiv one at a time, and
// resolves zero divisors locally with saturated results.
module div_dispatch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = div_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dividend,
    input  logic [W-1:0] in_divisor,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_quotient,
    output logic         out_dz,
    output logic         div_go,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic         div_rdy,
    input  logic [W-1:0] div_quotient
);

    import div_pkg::*;

    localparam int unsigned  DW      = 2 * W;
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    state_t        state_q, state_d;
    logic          rdy_q;
    logic          go_q, go_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic          vld_q, vld_d;
    logic [W-1:0]  quo_q, quo_d;
    logic          dz_q, dz_d;
    logic          dz_pend_q, dz_pend_d;
    logic          dz_neg_q, dz_neg_d;

    logic          fifo_pop_c;
    logic          fifo_full_c;
    logic          fifo_empty_c;
    logic [DW-1:0] fifo_head_c;
    logic [W-1:0]  head_dividend_c;
    logic [W-1:0]  head_divisor_c;
    logic          rdy_rise_c;
    logic          slot_free_c;

    div_req_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_vld),
        .pop_i   (fifo_pop_c),
        .wdata_i ({in_dividend, in_divisor}),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign {head_dividend_c, head_divisor_c} = fifo_head_c;

    assign rdy_rise_c  = div_rdy && !rdy_q;
    assign slot_free_c = !vld_q || out_rdy;

    assign in_rdy       = !fifo_full_c;
    assign out_vld      = vld_q;
    assign out_quotient = quo_q;
    assign out_dz       = dz_q;
    assign div_go       = go_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

    // Next-state, pop decision and slot update.
    always_comb begin
        state_d    = state_q;
        fifo_pop_c = 1'b0;
        go_d       = 1'b0;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        vld_d      = vld_q && !out_rdy;
        quo_d      = quo_q;
        dz_d       = dz_q;
        dz_pend_d  = 1'b0;
        dz_neg_d   = dz_neg_q;

        // A zero-divisor pop lands in the slot on the following edge.
        if (dz_pend_q) begin
            vld_d = 1'b1;
            quo_d = dz_neg_q ? SAT_NEG : SAT_POS;
            dz_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty_c && slot_free_c && !dz_pend_q) begin
                    fifo_pop_c = 1'b1;
                    if (head_divisor_c == '0) begin
                        dz_pend_d = 1'b1;
                        dz_neg_d  = head_dividend_c[W-1];
                    end else begin
                        dvd_d   = head_dividend_c;
                        dvs_d   = head_divisor_c;
                        go_d    = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rdy_rise_c) begin
                    vld_d   = 1'b1;
                    quo_d   = div_quotient;
                    dz_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, result and div_rdy history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            go_q      <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            vld_q     <= 1'b0;
            quo_q     <= '0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
            dz_neg_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= div_rdy;
            go_q      <= go_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            vld_q     <= vld_d;
            quo_q     <= quo_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
            dz_neg_q  <= dz_neg_d;
        end
    end

endmodule

// File: tb/tb_div_dispatch.sv
// Scoreboard bench for div_dispatch with a behavioural SDiv stand-in.
module tb_div_dispatch;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] out_quotient;
    logic         out_dz;
    logic         div_go;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_rdy;
    logic [W-1:0] div_quotient;

    div_dispatch #(.DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_quotient (out_quotient),
        .out_dz       (out_dz),
        .div_go       (div_go),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_rdy      (div_rdy),
        .div_quotient (div_quotient)
    );

    always #5 clk = ~clk;

    // SDiv stand-in: fixed latency after go, one-cycle rdy pulse.
    int           lat = 3;
    logic         m_rdy = 1'b0;
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_q = '0;
    logic         hold_hi = 1'b0;

    assign div_rdy      = m_rdy | hold_hi;
    assign div_quotient = m_q;

    always @(posedge clk) begin
        m_rdy <= 1'b0;
        if (div_go) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_a    <= div_dividend;
            m_b    <= div_divisor;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                m_rdy  <= 1'b1;
                m_q    <= (m_b == '0) ? '0 : W'($signed(m_a) / $signed(m_b));
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [W-1:0] q;
        logic         dz;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    exp_t sb[$];
    op_t  goq[$];
    int   checks = 0;
    int   errors = 0;
    logic go_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: results and issue pulses checked against expected queues.
    initial begin : monitor
        exp_t e;
        op_t  o;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_vld && out_rdy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h dz %0b expected none", out_quotient, out_dz);
                    end else begin
                        e = sb.pop_front();
                        chk("result_q", 32'(out_quotient), 32'(e.q));
                        chk("result_dz", 32'(out_dz), 32'(e.dz));
                    end
                end
                if (div_go) begin
                    chk("go_single_cycle", 32'(go_prev), 0);
                    chk("go_nonzero_divisor", 32'(div_divisor != '0), 1);
                    if (goq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_go: got %0h/%0h expected none", div_dividend, div_divisor);
                    end else begin
                        o = goq.pop_front();
                        chk("go_dividend", 32'(div_dividend), 32'(o.a));
                        chk("go_divisor", 32'(div_divisor), 32'(o.b));
                    end
                end
            end
            go_prev = div_go;
        end
    end

    // Offer one request, wait for acceptance, record its expectations.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic edz);
        int t = 0;
        in_vld      = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        while (!in_rdy && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_rdy 0 expected 1");
            in_vld = 1'b0;
        end else begin
            sb.push_back('{q: eq, dz: edz});
            if (b != '0) goq.push_back('{a: a, b: b});
            @(posedge clk);
            #1;
            in_vld = 1'b0;
        end
    endtask

    task automatic wait_vld(input int maxc);
        int t = 0;
        while (!out_vld && t < maxc) begin
            @(negedge clk);
            t++;
        end
        chk("wait_out_vld", 32'(out_vld), 1);
    endtask

    task automatic drain(input int maxc);
        int t = 0;
        while ((sb.size() != 0 || goq.size() != 0) && t < maxc) begin
            @(negedge clk);
            t++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 0);
        chk("drain_goq_empty", 32'(goq.size()), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        in_vld      = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_rdy     = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_quotient", 32'(out_quotient), 0);
        chk("rst_out_dz", 32'(out_dz), 0);
        chk("rst_div_go", 32'(div_go), 0);
        chk("rst_div_dividend", 32'(div_dividend), 0);
        chk("rst_div_divisor", 32'(div_divisor), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single divide: go one cycle after push, result held one cycle
        push(16'h0008, 16'h0002, 16'h0004, 1'b0);
        @(negedge clk);
        chk("t1_go_before_pop", 32'(div_go), 0);
        @(negedge clk);
        chk("t1_go_pulse", 32'(div_go), 1);
        chk("t1_go_dividend", 32'(div_dividend), 32'h0008);
        chk("t1_go_divisor", 32'(div_divisor), 32'h0002);
        @(negedge clk);
        chk("t1_go_dropped", 32'(div_go), 0);
        wait_vld(30);
        @(negedge clk);
        chk("t1_vld_one_cycle", 32'(out_vld), 0);
        drain(50);

        // Divide-by-zero: result two edges after push, no go
        push(16'h0005, 16'h0000, 16'h7FFF, 1'b1);
        @(negedge clk);
        chk("t2a_vld_edge0", 32'(out_vld), 0);
        @(negedge clk);
        chk("t2a_vld_edge1", 32'(out_vld), 0);
        @(negedge clk);
        chk("t2a_vld_edge2", 32'(out_vld), 1);
        @(posedge clk);
        #1;
        push(16'hFFFB, 16'h0000, 16'h8000, 1'b1);
        @(negedge clk);
        chk("t2b_vld_edge0", 32'(out_vld), 0);
        @(negedge clk);
        chk("t2b_vld_edge1", 32'(out_vld), 0);
        @(negedge clk);
        chk("t2b_vld_edge2", 32'(out_vld), 1);
        drain(50);

        // Back-pressure: slot plus DEPTH queued, sixth offer refused
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(16'h0064, 16'h000A, 16'h000A, 1'b0);
        end
        chk("t3_full", 32'(in_rdy), 0);
        in_vld      = 1'b1;
        in_dividend = 16'h0064;
        in_divisor  = 16'h000A;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t3_sixth_refused", 32'(in_rdy), 0);
        end
        in_vld = 1'b0;
        wait_vld(50);
        chk("t3_still_full", 32'(in_rdy), 0);
        out_rdy = 1'b1;
        drain(300);
        chk("t3_no_sixth", 32'(out_vld), 0);
        chk("t3_empty_again", 32'(in_rdy), 1);

        // Mixed stream keeps order across the zero-divisor path
        push(16'h0010, 16'h0004, 16'h0004, 1'b0);
        push(16'h0003, 16'h0000, 16'h7FFF, 1'b1);
        push(16'hFFF0, 16'h0002, 16'hFFF8, 1'b0);
        drain(100);

        // Reset during WAIT with two requests queued
        push(16'h0008, 16'h0002, 16'h0004, 1'b0);
        push(16'h000C, 16'h0003, 16'h0004, 1'b0);
        push(16'h0006, 16'h0002, 16'h0003, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        goq.delete();
        @(negedge clk);
        chk("t5_rst_out_vld", 32'(out_vld), 0);
        chk("t5_rst_div_go", 32'(div_go), 0);
        chk("t5_rst_in_rdy", 32'(in_rdy), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_late_rdy_ignored", 32'(out_vld), 0);
        @(posedge clk);
        #1;
        push(16'h0008, 16'h0002, 16'h0004, 1'b0);
        drain(50);

        // div_rdy held high across issue is not a completion
        hold_hi = 1'b1;
        @(posedge clk);
        #1;
        push(16'h0008, 16'h0002, 16'h0004, 1'b0);
        repeat (12) @(negedge clk);
        chk("t6_no_capture_while_high", 32'(out_vld), 0);
        chk("t6_result_pending", 32'(sb.size()), 1);
        @(posedge clk);
        #1;
        hold_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hold_hi = 1'b1;
        @(posedge clk);
        #1;
        hold_hi = 1'b0;
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
